// File: rtl/idea_pkg.sv
// Shared types and key-schedule helper for the iterative IDEA controller.
package idea_pkg;

    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int NUM_SUBKEYS = 52;
    localparam int ROT         = 25;

    // Subkey idx: chunk (idx mod 8) of the key rotated left by ROT*(idx div 8).
    // Chunk 0 is the most significant 16 bits.
    function automatic word_t subkey(input logic [127:0] key, input int idx);
        logic [255:0] dbl;
        logic [127:0] rk;
        int           amt;
        amt = (ROT * (idx / 8)) % 128;
        dbl = {key, key} << amt;
        rk  = dbl[255:128];
        return word_t'(rk >> (16 * (7 - (idx % 8))));
    endfunction

endpackage

// File: rtl/idea_key_sched.sv
// Combinational key schedule: selects the six subkeys of the current round
// and the four subkeys of the output transformation from the key register.
module idea_key_sched
    import idea_pkg::*;
#(
    parameter int NUM_ROUNDS = 8
) (
    input  logic [127:0] key,
    input  logic [2:0]   rnd,
    output word_t        z_round [6],
    output word_t        z_final [4]
);

    localparam int T = 6 * NUM_ROUNDS;

    word_t       z_all [NUM_SUBKEYS];
    logic [5:0]  base;

    assign base = 6'(rnd) * 6'd6;

    for (genvar g = 0; g < NUM_SUBKEYS; g++) begin : g_all
        assign z_all[g] = subkey(key, g);
    end

    for (genvar g = 0; g < 6; g++) begin : g_round
        assign z_round[g] = z_all[base + 6'(g)];
    end

    for (genvar g = 0; g < 4; g++) begin : g_final
        assign z_final[g] = z_all[T + g];
    end

endmodule

// File: rtl/inmultire.sv
// Multiplication modulo 65537 on 16-bit words; a zero operand or result
// stands for 65536. Uses the low/high folding identity 2^16 == -1.
module inmultire (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);

    logic [31:0] prod;
    logic [15:0] lo;
    logic [15:0] hi;

    // Fold the 32-bit product; zero operands are handled as -1 mod 65537.
    always_comb begin
        prod = 32'(a) * 32'(b);
        lo   = prod[15:0];
        hi   = prod[31:16];
        y    = 16'h0;
        if (a == 16'h0) begin
            y = 16'd1 - b;
        end else if (b == 16'h0) begin
            y = 16'd1 - a;
        end else begin
            y = lo - hi + {15'b0, (lo < hi)};
        end
    end

endmodule

// File: rtl/round.sv
// One full combinational IDEA round. Outputs carry the middle-word swap;
// the output transformation undoes it.
module round (
    input  logic [15:0] x1,
    input  logic [15:0] x2,
    input  logic [15:0] x3,
    input  logic [15:0] x4,
    input  logic [15:0] z1,
    input  logic [15:0] z2,
    input  logic [15:0] z3,
    input  logic [15:0] z4,
    input  logic [15:0] z5,
    input  logic [15:0] z6,
    output logic [15:0] y1,
    output logic [15:0] y2,
    output logic [15:0] y3,
    output logic [15:0] y4
);

    logic [15:0] a, b, c, d;
    logic [15:0] e, f, g, h, i, j;

    inmultire u_mul_a (.a(x1), .b(z1), .y(a));
    inmultire u_mul_d (.a(x4), .b(z4), .y(d));
    inmultire u_mul_g (.a(e),  .b(z5), .y(g));
    inmultire u_mul_i (.a(h),  .b(z6), .y(i));

    // Additions, XOR mixing and output combination of the round.
    always_comb begin
        b  = x2 + z2;
        c  = x3 + z3;
        e  = a ^ c;
        f  = b ^ d;
        h  = f + g;
        j  = g + i;
        y1 = a ^ i;
        y2 = c ^ i;
        y3 = b ^ j;
        y4 = d ^ j;
    end

endmodule

// File: rtl/idea_iter_ctrl.sv
// Iterative IDEA encryption controller: one shared round datapath, one
// round per clock, then the output transformation into registered C1..C4.
// Optional build macro IDEA_KEY_CACHE_EN adds KEY_LOAD so a previously
// captured key can be reused across blocks.
//
// Handshake: a transfer happens on a rising edge where VALID and READY are
// both high; IN_READY is high only in IDLE, OUT_VALID stays high with C
// stable until OUT_READY is seen.
module idea_iter_ctrl
    import idea_pkg::*;
#(
    parameter int NUM_ROUNDS = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [15:0]  P1,
    input  logic [15:0]  P2,
    input  logic [15:0]  P3,
    input  logic [15:0]  P4,
    input  logic [127:0] KEY,
`ifdef IDEA_KEY_CACHE_EN
    input  logic         KEY_LOAD,
`endif
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [15:0]  C1,
    output logic [15:0]  C2,
    output logic [15:0]  C3,
    output logic [15:0]  C4,
    output state_t       STATE
);

    localparam logic [2:0] LAST_RND = 3'(NUM_ROUNDS - 1);

    state_t        state;
    state_t        state_nxt;
    logic [2:0]    rnd;
    logic [127:0]  key_reg;
    word_t         x1, x2, x3, x4;
    word_t         y1, y2, y3, y4;
    word_t         zr [6];
    word_t         zf [4];
    word_t         c1_nxt, c4_nxt;
    logic          accept;
    logic          key_capture;

    assign IN_READY = (state == IDLE);
    assign accept   = IN_VALID && IN_READY;
    assign STATE    = state;

`ifdef IDEA_KEY_CACHE_EN
    assign key_capture = accept && KEY_LOAD;
`else
    assign key_capture = accept;
`endif

    idea_key_sched #(.NUM_ROUNDS(NUM_ROUNDS)) u_key_sched (
        .key     (key_reg),
        .rnd     (rnd),
        .z_round (zr),
        .z_final (zf)
    );

    round u_round (
        .x1 (x1),    .x2 (x2),    .x3 (x3),    .x4 (x4),
        .z1 (zr[0]), .z2 (zr[1]), .z3 (zr[2]),
        .z4 (zr[3]), .z5 (zr[4]), .z6 (zr[5]),
        .y1 (y1),    .y2 (y2),    .y3 (y3),    .y4 (y4)
    );

    inmultire u_mul_c1 (.a(x1), .b(zf[0]), .y(c1_nxt));
    inmultire u_mul_c4 (.a(x4), .b(zf[3]), .y(c4_nxt));

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (IN_VALID)          state_nxt = ROUND;
            ROUND:   if (rnd == LAST_RND)   state_nxt = FINAL;
            FINAL:                          state_nxt = DONE;
            DONE:    if (OUT_READY)         state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    // Block state, round counter and key register; rnd saturates at the last round.
    always_ff @(posedge CLK) begin
        if (RST) begin
            x1      <= '0;
            x2      <= '0;
            x3      <= '0;
            x4      <= '0;
            rnd     <= '0;
            key_reg <= '0;
        end else begin
            if (key_capture) begin
                key_reg <= KEY;
            end
            if (accept) begin
                x1  <= P1;
                x2  <= P2;
                x3  <= P3;
                x4  <= P4;
                rnd <= '0;
            end else if (state == ROUND) begin
                x1 <= y1;
                x2 <= y2;
                x3 <= y3;
                x4 <= y4;
                if (rnd != LAST_RND) begin
                    rnd <= rnd + 3'd1;
                end
            end
        end
    end

    // Output transformation into the ciphertext registers; middle words swap back.
    always_ff @(posedge CLK) begin
        if (RST) begin
            C1        <= '0;
            C2        <= '0;
            C3        <= '0;
            C4        <= '0;
            OUT_VALID <= 1'b0;
        end else if (state == FINAL) begin
            C1        <= c1_nxt;
            C2        <= x3 + zf[1];
            C3        <= x2 + zf[2];
            C4        <= c4_nxt;
            OUT_VALID <= 1'b1;
        end else if ((state == DONE) && OUT_READY) begin
            OUT_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_idea_iter_ctrl.sv
// Testbench for idea_iter_ctrl. Reference model computes IDEA directly from
// the algorithm (modulo arithmetic, rotated key). Covers the key cache path
// when IDEA_KEY_CACHE_EN is defined.
module tb_idea_iter_ctrl;
    import idea_pkg::*;

    localparam int NR = 8;
    localparam logic [127:0] STD_KEY = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
    localparam logic [63:0]  STD_P   = 64'h0000_0001_0002_0003;
    localparam logic [63:0]  STD_C   = 64'h11FB_ED2B_0198_6DE5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [15:0]  p1 = '0, p2 = '0, p3 = '0, p4 = '0;
    logic [127:0] key = '0;
    logic         key_load = 1'b1;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [15:0]  c1, c2, c3, c4;
    state_t       state;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    // clock / reset block
    always #5 clk = ~clk;

    idea_iter_ctrl #(.NUM_ROUNDS(NR)) dut (
        .CLK       (clk),
        .RST       (rst),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .P1        (p1),
        .P2        (p2),
        .P3        (p3),
        .P4        (p4),
        .KEY       (key),
`ifdef IDEA_KEY_CACHE_EN
        .KEY_LOAD  (key_load),
`endif
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .C1        (c1),
        .C2        (c2),
        .C3        (c3),
        .C4        (c4),
        .STATE     (state)
    );

    // ---------------- reference model ----------------
    function automatic logic [15:0] m_mul(input logic [15:0] a, input logic [15:0] b);
        longint unsigned av, bv, r;
        av = (a == 16'h0) ? 64'd65536 : 64'(a);
        bv = (b == 16'h0) ? 64'd65536 : 64'(b);
        r  = (av * bv) % 64'd65537;
        return (r == 64'd65536) ? 16'h0 : r[15:0];
    endfunction

    function automatic logic [15:0] m_subkey(input logic [127:0] k0, input int i);
        logic [127:0] k;
        k = k0;
        for (int s = 0; s < i / 8; s++) k = {k[102:0], k[127:103]};
        return k[127 - 16 * (i % 8) -: 16];
    endfunction

    function automatic logic [63:0] m_encrypt(input logic [63:0] p, input logic [127:0] k);
        logic [15:0] z [52];
        logic [15:0] x1, x2, x3, x4, a, b, c, d, t0, t1, t2;
        for (int i = 0; i < 52; i++) z[i] = m_subkey(k, i);
        {x1, x2, x3, x4} = p;
        for (int r = 0; r < NR; r++) begin
            a  = m_mul(x1, z[6*r]);
            b  = x2 + z[6*r+1];
            c  = x3 + z[6*r+2];
            d  = m_mul(x4, z[6*r+3]);
            t0 = m_mul(a ^ c, z[6*r+4]);
            t1 = m_mul((b ^ d) + t0, z[6*r+5]);
            t2 = t0 + t1;
            x1 = a ^ t1;
            x2 = c ^ t1;
            x3 = b ^ t2;
            x4 = d ^ t2;
        end
        a = m_mul(x1, z[6*NR]);
        b = x3 + z[6*NR+1];
        c = x2 + z[6*NR+2];
        d = m_mul(x4, z[6*NR+3]);
        return {a, b, c, d};
    endfunction

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        w = 16'($urandom);
        if ($urandom_range(0, 3) == 0) w = 16'h0;
        return w;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] p, input logic [127:0] k, input logic kl, output bit to);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        to = !in_ready;
        {p1, p2, p3, p4} = p;
        key      = k;
        key_load = kl;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n, output bit to);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        to = !out_valid;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        repeat (3) tick();
        checks++;
        if (state !== IDLE) begin
            failures++;
            $display("FAIL reset_state got=%0d exp=%0d", state, IDLE);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if ({c1, c2, c3, c4} !== 64'h0) begin
            failures++;
            $display("FAIL reset_c got=%h exp=0", {c1, c2, c3, c4});
        end
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_std_vector();
        bit to;
        int n;
        send(STD_P, STD_KEY, 1'b1, to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL std_accept_timeout got=busy exp=ready");
        end
        wait_valid(n, to);
        checks++;
        if (n !== 9) begin
            failures++;
            $display("FAIL std_latency got=%0d exp=9", n);
        end
        checks++;
        if ({c1, c2, c3, c4} !== STD_C) begin
            failures++;
            $display("FAIL std_vector got=%h exp=%h", {c1, c2, c3, c4}, STD_C);
        end
        consume();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL std_release got=%b%b exp=01", out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        bit to;
        int n;
        logic [63:0] hold;
        send(STD_P, STD_KEY, 1'b1, to);
        wait_valid(n, to);
        hold = {c1, c2, c3, c4};
        checks++;
        if (hold !== m_encrypt(STD_P, STD_KEY)) begin
            failures++;
            $display("FAIL bp_value got=%h exp=%h", hold, m_encrypt(STD_P, STD_KEY));
        end
        for (int i = 0; i < 20; i++) begin
            if (i == 7) begin
                in_valid = 1'b1;
                {p1, p2, p3, p4} = 64'hDEAD_BEEF_0000_1111;
            end
            tick();
            checks++;
            if ({c1, c2, c3, c4} !== hold || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d got=%h v=%b r=%b exp=%h v=1 r=0",
                         i, {c1, c2, c3, c4}, out_valid, in_ready, hold);
            end
        end
        in_valid = 1'b0;
        consume();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release got=%b%b exp=01", out_valid, in_ready);
        end
    endtask

    task automatic test_busy_input();
        bit to;
        int n;
        send(STD_P, STD_KEY, 1'b1, to);
        tick();
        tick();
        {p1, p2, p3, p4} = {rand_word(), rand_word(), rand_word(), 16'h1234};
        key = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(n, to);
        checks++;
        if ({c1, c2, c3, c4} !== STD_C || to) begin
            failures++;
            $display("FAIL busy_ignore got=%h exp=%h", {c1, c2, c3, c4}, STD_C);
        end
        consume();
    endtask

    task automatic test_reset_mid();
        bit to;
        int n;
        logic [63:0] p;
        logic [127:0] k;
        send(STD_P, STD_KEY, 1'b1, to);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (state !== IDLE || out_valid !== 1'b0 || {c1, c2, c3, c4} !== 64'h0) begin
            failures++;
            $display("FAIL rst_mid got=st%0d v=%b c=%h exp=st0 v=0 c=0",
                     state, out_valid, {c1, c2, c3, c4});
        end
        rst = 1'b0;
        p = {rand_word(), rand_word(), rand_word(), rand_word()};
        k = {$urandom, $urandom, $urandom, $urandom};
        send(p, k, 1'b1, to);
        wait_valid(n, to);
        checks++;
        if ({c1, c2, c3, c4} !== m_encrypt(p, k) || n !== 9) begin
            failures++;
            $display("FAIL rst_recover got=%h lat=%0d exp=%h lat=9", {c1, c2, c3, c4}, n, m_encrypt(p, k));
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || {c1, c2, c3, c4} !== 64'h0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_done got=v%b c=%h r=%b exp=v0 c=0 r=1", out_valid, {c1, c2, c3, c4}, in_ready);
        end
    endtask

    task automatic test_zero();
        bit to;
        int n;
        logic [63:0] p;
        for (int i = 0; i < 3; i++) begin
            p = (i == 0) ? 64'h0 : {rand_word(), 16'h0, rand_word(), 16'h0};
            send(p, 128'h0, 1'b1, to);
            wait_valid(n, to);
            checks++;
            if ({c1, c2, c3, c4} !== m_encrypt(p, 128'h0)) begin
                failures++;
                $display("FAIL zero_%0d got=%h exp=%h", i, {c1, c2, c3, c4}, m_encrypt(p, 128'h0));
            end
            consume();
        end
    endtask

    task automatic test_random();
        bit to;
        int n;
        logic [63:0] p, hold, exp;
        logic [127:0] k;
        for (int i = 0; i < 16; i++) begin
            p = {rand_word(), rand_word(), rand_word(), rand_word()};
            k = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 5) == 0) k[127:64] = '0;
            send(p, k, 1'b1, to);
            exp_q.push_back(m_encrypt(p, k));
            wait_valid(n, to);
            hold = {c1, c2, c3, c4};
            repeat ($urandom_range(0, 3)) tick();
            exp = exp_q.pop_front();
            checks++;
            if ({c1, c2, c3, c4} !== exp || hold !== exp || to) begin
                failures++;
                $display("FAIL random_%0d got=%h first=%h exp=%h", i, {c1, c2, c3, c4}, hold, exp);
            end
            consume();
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] blk_p [4];
        logic [127:0] blk_k [4];
        int acc_cyc [4];
        int nacc, nout, cyc;
        logic [63:0] exp;
        bit took;
        for (int i = 0; i < 4; i++) begin
            blk_p[i] = {rand_word(), rand_word(), rand_word(), rand_word()};
            blk_k[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        nacc = 0;
        nout = 0;
        cyc = 0;
        out_ready = 1'b1;
        {p1, p2, p3, p4} = blk_p[0];
        key = blk_k[0];
        in_valid = 1'b1;
        while (cyc < 200 && (nacc < 4 || nout < 4)) begin
            if (out_valid) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
                checks++;
                if ({c1, c2, c3, c4} !== exp) begin
                    failures++;
                    $display("FAIL b2b_out_%0d got=%h exp=%h", nout, {c1, c2, c3, c4}, exp);
                end
                nout++;
            end
            took = in_ready && in_valid;
            if (took) begin
                acc_cyc[nacc] = cyc;
                exp_q.push_back(m_encrypt(blk_p[nacc], blk_k[nacc]));
            end
            tick();
            cyc++;
            if (took) begin
                nacc++;
                if (nacc < 4) begin
                    {p1, p2, p3, p4} = blk_p[nacc];
                    key = blk_k[nacc];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (nacc !== 4 || nout !== 4) begin
            failures++;
            $display("FAIL b2b_count got=acc%0d out%0d exp=acc4 out4", nacc, nout);
        end
        for (int i = 1; i < 4; i++) begin
            if (i < nacc) begin
                checks++;
                if (acc_cyc[i] - acc_cyc[i-1] !== 11) begin
                    failures++;
                    $display("FAIL b2b_interval_%0d got=%0d exp=11", i, acc_cyc[i] - acc_cyc[i-1]);
                end
            end
        end
    endtask

`ifdef IDEA_KEY_CACHE_EN
    task automatic test_key_cache();
        bit to;
        int n;
        logic [63:0] pa, pb;
        logic [127:0] ka;
        pa = {rand_word(), rand_word(), rand_word(), rand_word()};
        pb = {rand_word(), rand_word(), rand_word(), rand_word()};
        ka = {$urandom, $urandom, $urandom, $urandom};
        send(pa, ka, 1'b1, to);
        wait_valid(n, to);
        checks++;
        if ({c1, c2, c3, c4} !== m_encrypt(pa, ka)) begin
            failures++;
            $display("FAIL cache_load got=%h exp=%h", {c1, c2, c3, c4}, m_encrypt(pa, ka));
        end
        consume();
        send(pb, {128{1'b1}}, 1'b0, to);
        wait_valid(n, to);
        checks++;
        if ({c1, c2, c3, c4} !== m_encrypt(pb, ka)) begin
            failures++;
            $display("FAIL cache_reuse got=%h exp=%h", {c1, c2, c3, c4}, m_encrypt(pb, ka));
        end
        consume();
        key_load = 1'b1;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_std_vector();
        test_backpressure();
        test_busy_input();
        test_reset_mid();
        test_zero();
        test_random();
        test_back_to_back();
`ifdef IDEA_KEY_CACHE_EN
        test_key_cache();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
